// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the RAM16K two-requester arbiter: ownership state
// encoding, default geometry and the locked-burst continuation rule.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } own_state_t;

  localparam int DEF_AW        = 14;
  localparam int DEF_DW        = 16;
  localparam int DEF_MAX_BURST = 8;

  // True when a granted locked access may keep ownership for another beat.
  function automatic logic burst_continue(input logic       lock,
                                          input logic [7:0] count,
                                          input logic [8:0] limit);
    return lock && (({1'b0, count} + 9'd1) < limit);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational two-way priority picker: a lone request always wins, a tie
// goes to the requester that is not 'last' (last = 1 favours req0).
module mem_arb_pick (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic pick0,
  output logic pick1
);

  assign pick0 = req0 && (!req1 || last);
  assign pick1 = req1 && (!req0 || !last);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing a single-port RAM16K between a CPU data port (r0) and a
// loader (r1). Define MEM_ARB_RR_EN for round-robin ties; default is fixed r0.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW        = DEF_AW,
  parameter int DW        = DEF_DW,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic          r0_lock,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic          r1_lock,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic [DW-1:0] r1_rdata,
  output logic [DW-1:0] mem_in,
  output logic          mem_load,
  output logic [AW-1:0] mem_address,
  input  logic [DW-1:0] mem_out
);

  localparam logic [8:0] BURST_LIMIT = 9'(MAX_BURST);

  own_state_t state;
  logic [7:0] count;
  logic       last;
  logic       pick0;
  logic       pick1;

`ifndef MEM_ARB_RR_EN
  // Fixed priority: pretend r1 always won last, so every tie goes to r0.
  assign last = 1'b1;
`endif

  mem_arb_pick u_pick (
    .req0  (r0_req),
    .req1  (r1_req),
    .last  (last),
    .pick0 (pick0),
    .pick1 (pick1)
  );

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    r0_gnt = 1'b0;
    r1_gnt = 1'b0;
    case (state)
      IDLE: begin
        r0_gnt = pick0;
        r1_gnt = pick1;
      end
      OWN0:    r0_gnt = r0_req;
      OWN1:    r1_gnt = r1_req;
      default: ;
    endcase
  end

  always_comb begin
    mem_address = '0;
    mem_in      = '0;
    mem_load    = 1'b0;
    if (r0_gnt) begin
      mem_address = r0_addr;
      mem_in      = r0_wdata;
      mem_load    = r0_we;
    end else if (r1_gnt) begin
      mem_address = r1_addr;
      mem_in      = r1_wdata;
      mem_load    = r1_we;
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      r0_rdata  <= '0;
      r1_rdata  <= '0;
`ifdef MEM_ARB_RR_EN
      last      <= 1'b1;
`endif
    end else begin
      r0_rvalid <= r0_gnt && !r0_we;
      r1_rvalid <= r1_gnt && !r1_we;
      if (r0_gnt && !r0_we) r0_rdata <= mem_out;
      if (r1_gnt && !r1_we) r1_rdata <= mem_out;

      if (r0_gnt && burst_continue(r0_lock, count, BURST_LIMIT)) begin
        state <= OWN0;
        count <= count + 8'd1;
      end else if (r1_gnt && burst_continue(r1_lock, count, BURST_LIMIT)) begin
        state <= OWN1;
        count <= count + 8'd1;
      end else begin
        // Unlocked access, forced release, dropped request or no request.
        state <= IDLE;
        count <= '0;
      end

`ifdef MEM_ARB_RR_EN
      if (state == IDLE && (r0_gnt || r1_gnt)) last <= r1_gnt;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural RAM16K;
// expectations adapt to MEM_ARB_RR_EN where tie behaviour differs.
module tb_mem_arbiter;

  localparam int AW = 14;
  localparam int DW = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          r0_req, r0_we, r0_lock;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_wdata;
  logic          r0_gnt, r0_rvalid;
  logic [DW-1:0] r0_rdata;
  logic          r1_req, r1_we, r1_lock;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata;
  logic          r1_gnt, r1_rvalid;
  logic [DW-1:0] r1_rdata;
  logic [DW-1:0] mem_in;
  logic          mem_load;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_out;

  logic [DW-1:0] ram [0:(1<<AW)-1];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  assign mem_out = ram[mem_address];
  always @(posedge clock) if (mem_load) ram[mem_address] <= mem_in;

  mem_arbiter dut (
    .clock       (clock),
    .reset       (reset),
    .r0_req      (r0_req),
    .r0_we       (r0_we),
    .r0_lock     (r0_lock),
    .r0_addr     (r0_addr),
    .r0_wdata    (r0_wdata),
    .r0_gnt      (r0_gnt),
    .r0_rvalid   (r0_rvalid),
    .r0_rdata    (r0_rdata),
    .r1_req      (r1_req),
    .r1_we       (r1_we),
    .r1_lock     (r1_lock),
    .r1_addr     (r1_addr),
    .r1_wdata    (r1_wdata),
    .r1_gnt      (r1_gnt),
    .r1_rvalid   (r1_rvalid),
    .r1_rdata    (r1_rdata),
    .mem_in      (mem_in),
    .mem_load    (mem_load),
    .mem_address (mem_address),
    .mem_out     (mem_out)
  );

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic set0(input logic req, input logic we, input logic lock,
                      input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    r0_req = req; r0_we = we; r0_lock = lock; r0_addr = addr; r0_wdata = wdata;
  endtask

  task automatic set1(input logic req, input logic we, input logic lock,
                      input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    r1_req = req; r1_we = we; r1_lock = lock; r1_addr = addr; r1_wdata = wdata;
  endtask

  // Winner of the i-th cycle of the held tie, starting with r1 as last winner.
  function automatic logic tie_r0_wins(input int i);
`ifdef MEM_ARB_RR_EN
    return (i % 2) == 0;
`else
    return 1'b1;
`endif
  endfunction

  initial begin
    for (int a = 0; a < (1 << AW); a++) ram[a] = '0;
    ram[14'h0123] = 16'hBEEF;
    reset = 1'b1;
    set0(0, 0, 0, '0, '0);
    set1(0, 0, 0, '0, '0);

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check("rst_state", dut.state, 0);
    check("rst_count", dut.count, 0);
    check("rst_gnt", {r0_gnt, r1_gnt}, 0);
    check("rst_rvalid", {r0_rvalid, r1_rvalid}, 0);
    check("rst_rdata", {r0_rdata, r1_rdata}, 0);
    @(negedge clock);
    reset = 1'b0;

    // Single read by r0
    @(negedge clock);
    set0(1, 0, 0, 14'h0123, '0);
    #1;
    check("rd_r0_gnt", r0_gnt, 1);
    check("rd_r1_gnt", r1_gnt, 0);
    check("rd_addr", mem_address, 14'h0123);
    check("rd_load", mem_load, 0);
    @(posedge clock); #1;
    check("rd_r0_rvalid", r0_rvalid, 1);
    check("rd_r0_rdata", r0_rdata, 16'hBEEF);
    check("rd_r1_quiet", {r1_rvalid, r1_rdata}, 0);
    @(negedge clock);
    set0(0, 0, 0, '0, '0);
    @(posedge clock); #1;
    check("rd_rvalid_drop", r0_rvalid, 0);
    check("rd_rdata_hold", r0_rdata, 16'hBEEF);

    // Write then read by r1
    @(negedge clock);
    set1(1, 1, 0, 14'h3FFF, 16'h5A5A);
    #1;
    check("wr_r1_gnt", r1_gnt, 1);
    check("wr_load", mem_load, 1);
    check("wr_in", mem_in, 16'h5A5A);
    check("wr_addr", mem_address, 14'h3FFF);
    @(posedge clock); #1;
    check("wr_no_rvalid", r1_rvalid, 0);
    @(negedge clock);
    set1(1, 0, 0, 14'h3FFF, '0);
    #1;
    check("raw_gnt", r1_gnt, 1);
    check("raw_load", mem_load, 0);
    @(posedge clock); #1;
    check("raw_rvalid", r1_rvalid, 1);
    check("raw_rdata", r1_rdata, 16'h5A5A);
    @(negedge clock);
    set1(0, 0, 0, '0, '0);
    #1;
    check("idle_bus", {mem_address, mem_in, mem_load}, 0);

    // Held tie, both reading
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      set0(1, 0, 0, 14'h0123, '0);
      set1(1, 0, 0, 14'h3FFF, '0);
      #1;
      check($sformatf("tie_r0_gnt_%0d", i), r0_gnt, tie_r0_wins(i));
      check($sformatf("tie_r1_gnt_%0d", i), r1_gnt, !tie_r0_wins(i));
      @(posedge clock); #1;
      check($sformatf("tie_r0_rvalid_%0d", i), r0_rvalid, tie_r0_wins(i));
      check($sformatf("tie_r1_rvalid_%0d", i), r1_rvalid, !tie_r0_wins(i));
    end
    @(negedge clock);
    set0(0, 0, 0, '0, '0);
    set1(0, 0, 0, '0, '0);

    // r1 locked burst of 12 requests while r0 waits from cycle 1
    for (int i = 0; i < 13; i++) begin
      @(negedge clock);
      set1(i < 12, 0, 1, 14'h3FFF, '0);
      set0(i >= 1 && i <= 8, 0, 0, 14'h0123, '0);
      #1;
      check($sformatf("burst_r0_gnt_%0d", i), r0_gnt, i == 8);
      check($sformatf("burst_r1_gnt_%0d", i), r1_gnt, i != 8 && i < 12);
      @(posedge clock); #1;
      if (i == 0) check("burst_own1", {dut.state, dut.count}, {2'd2, 8'd1});
      if (i == 7) check("burst_forced", {dut.state, dut.count}, 0);
      if (i == 11) check("burst_resume", {dut.state, dut.count}, {2'd2, 8'd3});
      if (i == 12) check("burst_end", {dut.state, dut.count}, 0);
    end

    // r0 locks, then drops req mid-burst
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      set0(i < 2, 0, 1, 14'h0123, '0);
      set1(i >= 1, 0, 0, 14'h3FFF, '0);
      #1;
      check($sformatf("rel_r0_gnt_%0d", i), r0_gnt, i < 2);
      check($sformatf("rel_r1_gnt_%0d", i), r1_gnt, i == 3);
      @(posedge clock); #1;
      if (i == 1) check("rel_own0", {dut.state, dut.count}, {2'd1, 8'd2});
      if (i == 2) check("rel_idle", {dut.state, dut.count}, 0);
    end
    @(negedge clock);
    set1(0, 0, 0, '0, '0);

    // Reset during a granted r0 read in OWN0
    @(negedge clock);
    set0(1, 0, 1, 14'h0123, '0);
    @(posedge clock); #1;
    check("rstb_own0", dut.state, 1);
    @(negedge clock);
    set1(1, 0, 0, 14'h3FFF, '0);
    reset = 1'b1;
    #1;
    check("rstb_r0_gnt", r0_gnt, 1);
    @(posedge clock); #1;
    check("rstb_rvalid", {r0_rvalid, r1_rvalid}, 0);
    check("rstb_state", {dut.state, dut.count}, 0);
    check("rstb_rdata", r0_rdata, 0);
    @(negedge clock);
    reset = 1'b0;
    set0(0, 0, 0, '0, '0);
    set1(0, 0, 0, '0, '0);
    #1;
    check("rstb_no_gnt", {r0_gnt, r1_gnt}, 0);
    @(negedge clock);
    set0(1, 0, 0, 14'h0123, '0);
    set1(1, 0, 0, 14'h3FFF, '0);
    #1;
    check("rstb_tie_r0", {r0_gnt, r1_gnt}, 2'b10);
    @(posedge clock); #1;
    check("rstb_tie_rdata", {r0_rvalid, r0_rdata}, {1'b1, 16'hBEEF});
    @(negedge clock);
    set0(0, 0, 0, '0, '0);
    set1(0, 0, 0, '0, '0);
    @(posedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
